// File: rtl/mem_refill_arbiter.sv
// Arbitrates the single main-memory burst port between I-cache refills and D-cache refills/writebacks.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed D-cache priority with alternation on simultaneous requests.
`timescale 1ns/1ps
module mem_refill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [CNT_W-1:0]  dc_wbeat,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              owner
);

    localparam int                OFF_W    = $clog2(LINE_WORDS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               owner_q, owner_nxt;
    logic               we_q, we_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic               grant_dc;
    logic               read_beat;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~OFF_MASK;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner, last_owner_nxt;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_dc = dc_req;
        if (dc_req && ic_req) grant_dc = ~last_owner;
    end
`else
    always_comb begin
        grant_dc = dc_req;
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_nxt = last_owner;
`endif
        case (state)
            IDLE: begin
                if (dc_req || ic_req) begin
                    state_nxt = CMD;
                    owner_nxt = grant_dc;
                    we_nxt    = grant_dc & dc_we;
                    addr_nxt  = line_base(grant_dc ? dc_addr : ic_addr);
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_nxt = grant_dc;
`endif
                end
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = we_q ? WRITE : READ;
                end
            end
            WRITE: begin
                // The counter holds on the final beat so it never wraps inside a burst.
                if (mem_wready) begin
                    if (cnt == LAST) state_nxt = DONE;
                    else             cnt_nxt   = cnt + 1'b1;
                end
            end
            READ: begin
                if (mem_rvalid) begin
                    if (cnt == LAST) state_nxt = DONE;
                    else             cnt_nxt   = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            owner_q <= owner_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= last_owner_nxt;
`endif
        end
    end

    // All outputs decode from state so an async reset silences them before the next edge.
    assign busy          = (state != IDLE);
    assign owner         = owner_q;
    assign mem_cmd_valid = (state == CMD);
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_we    = we_q;

    assign mem_wvalid = (state == WRITE);
    assign mem_wdata  = mem_wvalid ? dc_wdata : '0;
    assign dc_wbeat   = cnt;

    assign read_beat = (state == READ) && mem_rvalid;
    assign ic_rvalid = read_beat & ~owner_q;
    assign dc_rvalid = read_beat & owner_q;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

    assign ic_done = (state == DONE) & ~owner_q;
    assign dc_done = (state == DONE) & owner_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: cycle-vector table plus hand-written backpressure, reset and tie-break sequences.
`timescale 1ns/1ps
module tb_mem_refill_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic        ic_done;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [2:0]  dc_wbeat;
    logic [31:0] dc_rdata;
    logic        dc_rvalid;
    logic        dc_done;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_we;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;
    logic        owner;

    mem_refill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wbeat(dc_wbeat),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .owner(owner)
    );

    // D-cache line buffer: each word is tagged with its beat index.
    assign dc_wdata = 32'hA500_0000 | {29'd0, dc_wbeat};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ic_req, dc_req, dc_we, cmd_ready, rvalid, wready;
        logic [31:0] rdata;
        logic        e_busy, e_owner, e_cmd_valid, e_cmd_we;
        logic        e_ic_rvalid, e_dc_rvalid, e_ic_done, e_dc_done, e_wvalid;
        logic [31:0] e_rdata;
        logic [2:0]  e_wbeat;
        logic [31:0] e_cmd_addr;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] IC_LINE = 32'h0000_1220;
    localparam logic [31:0] DC_LINE = 32'h8000_0040;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic gen_idle();
        vec_t v = '{default: '0};
        tbl.push_back(v);
    endtask

    // One read burst: IDLE grant row, CMD, 8 beats, DONE. The non-owner's request level is 'hold'.
    task automatic gen_read(input logic own, input logic hold, input logic [31:0] base);
        vec_t v = '{default: '0};
        v.ic_req = own ? hold : 1'b1;
        v.dc_req = own ? 1'b1 : hold;
        v.rvalid = 1'b1;
        v.rdata  = 32'hDEAD_BEEF;
        tbl.push_back(v);
        v.cmd_ready   = 1'b1;
        v.e_busy      = 1'b1;
        v.e_owner     = own;
        v.e_cmd_valid = 1'b1;
        v.e_cmd_addr  = own ? DC_LINE : IC_LINE;
        tbl.push_back(v);
        v.e_cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            v.rdata       = base + k;
            v.e_rdata     = base + k;
            v.e_ic_rvalid = ~own;
            v.e_dc_rvalid = own;
            tbl.push_back(v);
        end
        v.e_ic_rvalid = 1'b0;
        v.e_dc_rvalid = 1'b0;
        v.rdata       = 32'hDEAD_BEEF;
        if (own) v.dc_req = 1'b0; else v.ic_req = 1'b0;
        v.e_ic_done = ~own;
        v.e_dc_done = own;
        tbl.push_back(v);
    endtask

    // One D-cache writeback; stall[k] inserts a wready=0 cycle before beat k is accepted.
    task automatic gen_write(input logic [7:0] stall);
        vec_t v = '{default: '0};
        v.dc_req = 1'b1;
        v.dc_we  = 1'b1;
        v.rvalid = 1'b1;
        v.rdata  = 32'hDEAD_BEEF;
        tbl.push_back(v);
        v.cmd_ready   = 1'b1;
        v.e_busy      = 1'b1;
        v.e_owner     = 1'b1;
        v.e_cmd_valid = 1'b1;
        v.e_cmd_we    = 1'b1;
        v.e_cmd_addr  = DC_LINE;
        tbl.push_back(v);
        v.e_cmd_valid = 1'b0;
        v.e_wvalid    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            v.e_wbeat = 3'(k);
            if (stall[k]) begin
                v.wready = 1'b0;
                tbl.push_back(v);
            end
            v.wready = 1'b1;
            tbl.push_back(v);
        end
        v.wready    = 1'b0;
        v.e_wvalid  = 1'b0;
        v.dc_req    = 1'b0;
        v.e_dc_done = 1'b1;
        tbl.push_back(v);
    endtask

    initial begin
        int wr_acc;
        int nb;
        int n_done;
        int first_done;
        int exp_first;
        bit got;
        bit drop_ic;
        bit drop_dc;

        rst_n = 1'b0;
        ic_req = 1'b0; ic_addr = 32'h0000_1234;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = 32'h8000_0040;
        mem_cmd_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;

        gen_read(1'b1, 1'b1, 32'h1000);
        gen_read(1'b0, 1'b0, 32'h2000);
        gen_idle();
        gen_read(1'b1, 1'b1, 32'h3000);
        gen_read(1'b0, 1'b0, 32'h4000);
        gen_idle();
        gen_read(1'b0, 1'b0, 32'h0);
        gen_idle();
        gen_write(8'b0010_0100);
        gen_idle();

        #12;
        chk("reset busy", busy, 0);
        chk("reset owner", owner, 0);
        chk("reset cmd_valid", mem_cmd_valid, 0);
        chk("reset cmd_addr", mem_cmd_addr, 0);
        chk("reset ic_rvalid", ic_rvalid, 0);
        chk("reset dc_rvalid", dc_rvalid, 0);
        chk("reset wvalid", mem_wvalid, 0);
        chk("reset wbeat", dc_wbeat, 0);
        #10 rst_n = 1'b1;

        wr_acc = 0;
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            ic_req = tbl[i].ic_req; dc_req = tbl[i].dc_req; dc_we = tbl[i].dc_we;
            mem_cmd_ready = tbl[i].cmd_ready; mem_rvalid = tbl[i].rvalid;
            mem_rdata = tbl[i].rdata; mem_wready = tbl[i].wready;
            #3;
            chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("row%0d cmd_valid", i), mem_cmd_valid, tbl[i].e_cmd_valid);
            chk($sformatf("row%0d ic_rvalid", i), ic_rvalid, tbl[i].e_ic_rvalid);
            chk($sformatf("row%0d dc_rvalid", i), dc_rvalid, tbl[i].e_dc_rvalid);
            chk($sformatf("row%0d ic_done", i), ic_done, tbl[i].e_ic_done);
            chk($sformatf("row%0d dc_done", i), dc_done, tbl[i].e_dc_done);
            chk($sformatf("row%0d wvalid", i), mem_wvalid, tbl[i].e_wvalid);
            if (tbl[i].e_busy) chk($sformatf("row%0d owner", i), owner, tbl[i].e_owner);
            if (tbl[i].e_cmd_valid) begin
                chk($sformatf("row%0d cmd_addr", i), mem_cmd_addr, tbl[i].e_cmd_addr);
                chk($sformatf("row%0d cmd_we", i), mem_cmd_we, tbl[i].e_cmd_we);
            end
            if (tbl[i].e_ic_rvalid) chk($sformatf("row%0d ic_rdata", i), ic_rdata, tbl[i].e_rdata);
            if (tbl[i].e_dc_rvalid) chk($sformatf("row%0d dc_rdata", i), dc_rdata, tbl[i].e_rdata);
            if (tbl[i].e_wvalid) begin
                chk($sformatf("row%0d wbeat", i), dc_wbeat, tbl[i].e_wbeat);
                chk($sformatf("row%0d wdata", i), mem_wdata, 32'hA500_0000 | {29'd0, tbl[i].e_wbeat});
            end
            if (mem_wvalid && tbl[i].wready) wr_acc++;
        end
        chk("write beats accepted", wr_acc, 8);

        // Tie after a D-cache grant: fixed priority picks D again, round robin picks I.
`ifdef ARB_ROUND_ROBIN_EN
        exp_first = 0;
`else
        exp_first = 1;
`endif
        @(posedge clk); #1;
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0; mem_cmd_ready = 1'b1; mem_rvalid = 1'b1; mem_wready = 1'b0;
        #3 chk("tie idle busy", busy, 0);
        @(posedge clk); #4;
        chk("tie grant owner", owner, exp_first);
        n_done = 0; first_done = -1; drop_ic = 0; drop_dc = 0;
        for (int c = 0; c < 60 && n_done < 2; c++) begin
            @(posedge clk); #1;
            if (drop_ic) ic_req = 1'b0;
            if (drop_dc) dc_req = 1'b0;
            #3;
            if (ic_done) begin drop_ic = 1; n_done++; if (first_done < 0) first_done = 0; end
            if (dc_done) begin drop_dc = 1; n_done++; if (first_done < 0) first_done = 1; end
        end
        @(posedge clk); #1 ic_req = 1'b0; dc_req = 1'b0;
        chk("tie both done", n_done, 2);
        chk("tie first done", first_done, exp_first);

        // Command backpressure, then reset in the middle of the read burst.
        @(posedge clk); #1;
        ic_req = 1'b1; mem_cmd_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #3 chk("bp idle busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mem_cmd_ready = (i == 5);
            #3;
            chk($sformatf("bp%0d cmd_valid", i), mem_cmd_valid, 1);
            chk($sformatf("bp%0d cmd_addr", i), mem_cmd_addr, IC_LINE);
            chk($sformatf("bp%0d cmd_we", i), mem_cmd_we, 0);
            chk($sformatf("bp%0d rvalid", i), ic_rvalid | dc_rvalid, 0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mem_rdata = 32'(k);
            #3 chk($sformatf("pre-reset beat%0d", k), {ic_rvalid, ic_rdata[30:0]}, {1'b1, 31'(k)});
        end
        @(posedge clk); #1;
        mem_rdata = 32'd3;
        #1 rst_n = 1'b0; ic_req = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset ic_rvalid", ic_rvalid, 0);
        chk("midreset ic_done", ic_done, 0);
        chk("midreset cmd_valid", mem_cmd_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        #3 chk("post-reset busy", busy, 0);

        ic_req = 1'b1; mem_cmd_ready = 1'b1; mem_rvalid = 1'b1;
        nb = 0; got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clk); #1;
            mem_rdata = 32'h300 + nb;
            #3;
            if (ic_rvalid) begin
                chk($sformatf("refill beat%0d", nb), ic_rdata, 32'h300 + nb);
                nb++;
            end
            if (ic_done) got = 1;
        end
        @(posedge clk); #1 ic_req = 1'b0; mem_rvalid = 1'b0;
        chk("refill beat count", nb, 8);
        chk("refill done seen", got, 1);
        #3 chk("refill back to idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
